// File: rtl/axil_cmd_master_pkg.sv
// rtl/axil_cmd_master_pkg.sv - shared FSM encoding and AXI response codes for the command master
package axil_cmd_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_WRESP = 3'd2,
        ST_READ  = 3'd3,
        ST_RDATA = 3'd4,
        ST_RSP   = 3'd5,
        ST_DRAIN = 3'd6
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // States in which the bus transaction is outstanding and the timeout counter runs.
    function automatic logic is_busy(input state_e s);
        return (s == ST_WRITE) || (s == ST_WRESP) || (s == ST_READ) || (s == ST_RDATA);
    endfunction

endpackage

// File: rtl/axil_cmd_master.sv
// rtl/axil_cmd_master.sv - single-outstanding command to AXI4-Lite master bridge with timeout and drain
module axil_cmd_master
    import axil_cmd_master_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 1024
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,

    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_write,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic                    rsp_timeout,

    output logic                    mmio_axi_awvalid,
    input  logic                    mmio_axi_awready,
    output logic [ADDR_WIDTH-1:0]   mmio_axi_awaddr,
    output logic [2:0]              mmio_axi_awprot,
    output logic                    mmio_axi_wvalid,
    input  logic                    mmio_axi_wready,
    output logic [DATA_WIDTH-1:0]   mmio_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] mmio_axi_wstrb,
    input  logic                    mmio_axi_bvalid,
    output logic                    mmio_axi_bready,
    input  logic [1:0]              mmio_axi_bresp,
    output logic                    mmio_axi_arvalid,
    input  logic                    mmio_axi_arready,
    output logic [ADDR_WIDTH-1:0]   mmio_axi_araddr,
    output logic [2:0]              mmio_axi_arprot,
    input  logic                    mmio_axi_rvalid,
    output logic                    mmio_axi_rready,
    input  logic [DATA_WIDTH-1:0]   mmio_axi_rdata,
    input  logic [1:0]              mmio_axi_rresp
);

    localparam int                CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e                    state_q, state_d;
    logic                      cmd_ready_q, cmd_ready_d;
    logic                      wr_q, wr_d;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
    logic [DATA_WIDTH/8-1:0]   wstrb_q, wstrb_d;
    logic                      awvalid_q, awvalid_d;
    logic                      wvalid_q, wvalid_d;
    logic                      arvalid_q, arvalid_d;
    logic                      bready_q, bready_d;
    logic                      rready_q, rready_d;
    logic                      owe_q, owe_d;
    logic                      rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]     rsp_rdata_q, rsp_rdata_d;
    logic [1:0]                rsp_resp_q, rsp_resp_d;
    logic                      rsp_timeout_q, rsp_timeout_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      tmo_enter;

    logic aw_hs, w_hs, ar_hs, b_hs, r_hs, timed_out;

    assign aw_hs     = awvalid_q && mmio_axi_awready;
    assign w_hs      = wvalid_q  && mmio_axi_wready;
    assign ar_hs     = arvalid_q && mmio_axi_arready;
    assign b_hs      = bready_q  && mmio_axi_bvalid;
    assign r_hs      = rready_q  && mmio_axi_rvalid;
    assign timed_out = is_busy(state_q) && (cnt_q == CNT_LAST);

    always_comb begin
        state_d       = state_q;
        cmd_ready_d   = cmd_ready_q;
        wr_d          = wr_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        awvalid_d     = awvalid_q;
        wvalid_d      = wvalid_q;
        arvalid_d     = arvalid_q;
        bready_d      = bready_q;
        rready_d      = rready_q;
        owe_d         = owe_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_resp_d    = rsp_resp_q;
        rsp_timeout_d = rsp_timeout_q;
        cnt_d         = cnt_q;
        tmo_enter     = 1'b0;

        // Address/data valids fall only on their own handshake, whatever state we are in.
        if (aw_hs) awvalid_d = 1'b0;
        if (w_hs)  wvalid_d  = 1'b0;
        if (ar_hs) arvalid_d = 1'b0;
        if (is_busy(state_q)) cnt_d = cnt_q + CNT_W'(1);

        case (state_q)
            ST_IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    cmd_ready_d   = 1'b0;
                    wr_d          = cmd_write;
                    addr_d        = cmd_addr;
                    wdata_d       = cmd_wdata;
                    wstrb_d       = cmd_wstrb;
                    cnt_d         = '0;
                    rsp_timeout_d = 1'b0;
                    if (cmd_write) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = ST_WRITE;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = ST_READ;
                    end
                end
            end
            ST_WRITE: begin
                if (timed_out) begin
                    tmo_enter = 1'b1;
                end else if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = ST_WRESP;
                end
            end
            ST_WRESP: begin
                if (b_hs) begin
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_resp_d  = mmio_axi_bresp;
                    rsp_rdata_d = '0;
                    state_d     = ST_RSP;
                end else if (timed_out) begin
                    tmo_enter = 1'b1;
                end
            end
            ST_READ: begin
                if (timed_out) begin
                    tmo_enter = 1'b1;
                end else if (ar_hs) begin
                    rready_d = 1'b1;
                    state_d  = ST_RDATA;
                end
            end
            ST_RDATA: begin
                if (r_hs) begin
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_resp_d  = mmio_axi_rresp;
                    rsp_rdata_d = mmio_axi_rdata;
                    state_d     = ST_RSP;
                end else if (timed_out) begin
                    tmo_enter = 1'b1;
                end
            end
            ST_RSP: begin
                // After a timeout the owed B/R may land while the response is still waiting.
                if (owe_q && (b_hs || r_hs)) begin
                    owe_d    = 1'b0;
                    bready_d = 1'b0;
                    rready_d = 1'b0;
                end
                if (rsp_valid_q && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (owe_d) begin
                        state_d = ST_DRAIN;
                    end else begin
                        cmd_ready_d = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end
            end
            ST_DRAIN: begin
                if (b_hs || r_hs) begin
                    owe_d       = 1'b0;
                    bready_d    = 1'b0;
                    rready_d    = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (tmo_enter) begin
            state_d       = ST_RSP;
            rsp_valid_d   = 1'b1;
            rsp_timeout_d = 1'b1;
            rsp_resp_d    = RESP_SLVERR;
            rsp_rdata_d   = '0;
            owe_d         = 1'b1;
            bready_d      = wr_q;
            rready_d      = !wr_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cmd_ready_q   <= 1'b0;
            wr_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            bready_q      <= 1'b0;
            rready_q      <= 1'b0;
            owe_q         <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= '0;
            rsp_timeout_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            wr_q          <= wr_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            arvalid_q     <= arvalid_d;
            bready_q      <= bready_d;
            rready_q      <= rready_d;
            owe_q         <= owe_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_resp_q    <= rsp_resp_d;
            rsp_timeout_q <= rsp_timeout_d;
            cnt_q         <= cnt_d;
        end
    end

    assign cmd_ready        = cmd_ready_q;
    assign rsp_valid        = rsp_valid_q;
    assign rsp_write        = wr_q;
    assign rsp_rdata        = rsp_rdata_q;
    assign rsp_resp         = rsp_resp_q;
    assign rsp_timeout      = rsp_timeout_q;
    assign mmio_axi_awvalid = awvalid_q;
    assign mmio_axi_awaddr  = addr_q;
    assign mmio_axi_awprot  = 3'b000;
    assign mmio_axi_wvalid  = wvalid_q;
    assign mmio_axi_wdata   = wdata_q;
    assign mmio_axi_wstrb   = wstrb_q;
    assign mmio_axi_bready  = bready_q;
    assign mmio_axi_arvalid = arvalid_q;
    assign mmio_axi_araddr  = addr_q;
    assign mmio_axi_arprot  = 3'b000;
    assign mmio_axi_rready  = rready_q;

endmodule
